// File: rtl/qspi_rom_reader_if.sv
// Host-side request/response bundle between the cartridge address decode and the QSPI ROM reader.
interface qspi_rom_reader_if #(
    parameter int ADDR_W = 12
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              valid;
    logic [7:0]        rdata;

    modport master (output req, addr, input busy, valid, rdata);
    modport slave  (input req, addr, output busy, valid, rdata);
endinterface

// File: rtl/qspi_rom_reader.sv
// Quad-SPI ROM read initiator: one byte per request, command/address/dummy/data nibbles,
// two clk cycles per nibble (sclk low then high).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | select high, waiting for req
// S_CMD   | shifting out the two command nibbles
// S_ADDR  | shifting out the six 24-bit address nibbles, MSB first
// S_DUMMY | DUMMY turnaround nibbles, bus released
// S_DATA  | two data nibbles captured from io_in
// S_DONE  | select high, valid pulse, rdata presented
module qspi_rom_reader #(
    parameter int         ADDR_W = 12,
    parameter int         DUMMY  = 4,
    parameter logic [7:0] CMD    = 8'hEB
) (
    input  logic                clk,
    input  logic                rst_n,
    qspi_rom_reader_if.slave    host,
    output logic                select,
    output logic                sclk,
    output logic [3:0]          io_out,
    output logic [3:0]          io_oe,
    input  logic [3:0]          io_in
);
    localparam int         N          = 10 + DUMMY;
    localparam logic [4:0] NIB_LAST   = 5'(N - 1);
    localparam logic [4:0] NIB_PEN    = 5'(N - 2);
    localparam logic [4:0] DATA_FIRST = 5'(8 + DUMMY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_DONE
    } state_t;

    state_t            state;
    state_t            nx_state;
    logic [4:0]        nib;
    logic [4:0]        nib_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [23:0]       faddr;
    logic [3:0]        shadow;
    logic [3:0]        nx_out;
    logic [3:0]        nx_oe;
    logic              busy_q;
    logic              valid_q;
    logic [7:0]        rdata_q;

    assign host.busy  = busy_q;
    assign host.valid = valid_q;
    assign host.rdata = rdata_q;

    // What the next nibble drives, decided from its index across the whole frame.
    always_comb begin
        nib_nx   = nib + 5'd1;
        faddr    = 24'(addr_q);
        nx_out   = 4'h0;
        nx_oe    = 4'h0;
        nx_state = S_DATA;
        if (nib_nx < 5'd2)
            nx_state = S_CMD;
        else if (nib_nx < 5'd8)
            nx_state = S_ADDR;
        else if (nib_nx < DATA_FIRST)
            nx_state = S_DUMMY;
        case (nib_nx)
            5'd1:    nx_out = CMD[3:0];
            5'd2:    nx_out = faddr[23:20];
            5'd3:    nx_out = faddr[19:16];
            5'd4:    nx_out = faddr[15:12];
            5'd5:    nx_out = faddr[11:8];
            5'd6:    nx_out = faddr[7:4];
            5'd7:    nx_out = faddr[3:0];
            default: nx_out = 4'h0;
        endcase
        if (nib_nx < 5'd8)
            nx_oe = 4'hF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            nib     <= 5'd0;
            addr_q  <= '0;
            shadow  <= 4'h0;
            select  <= 1'b1;
            sclk    <= 1'b0;
            io_out  <= 4'h0;
            io_oe   <= 4'h0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (host.req) begin
                        addr_q <= host.addr;
                        nib    <= 5'd0;
                        select <= 1'b0;
                        sclk   <= 1'b0;
                        busy_q <= 1'b1;
                        io_out <= CMD[7:4];
                        io_oe  <= 4'hF;
                        state  <= S_CMD;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    if (!sclk) begin
                        sclk <= 1'b1;
                    end else begin
                        // End of a high phase: the flash has had the whole phase to settle io_in.
                        sclk <= 1'b0;
                        if (state == S_DATA && nib == NIB_PEN)
                            shadow <= io_in;
                        if (nib == NIB_LAST) begin
                            rdata_q <= {shadow, io_in};
                            valid_q <= 1'b1;
                            select  <= 1'b1;
                            io_out  <= 4'h0;
                            io_oe   <= 4'h0;
                            state   <= S_DONE;
                        end else begin
                            nib    <= nib_nx;
                            io_out <= nx_out;
                            io_oe  <= nx_oe;
                            state  <= nx_state;
                        end
                    end
                end
            endcase
        end
    end
endmodule
